// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control bit positions,
// default field widths and the packed entry layout for the default configuration.
package pipe_pkg;

    localparam int CTRL_RW_BIT     = 0;
    localparam int CTRL_MEMREG_BIT = 1;

    localparam int PIPE_DATA_W   = 32;
    localparam int PIPE_ADDR_W   = 5;
    localparam int PIPE_CTRL_W   = 2;
    localparam int PIPE_NUM_DATA = 2;

    typedef struct packed {
        logic [PIPE_CTRL_W-1:0]               ctrl;
        logic [PIPE_ADDR_W-1:0]               rd_addr;
        logic [PIPE_NUM_DATA*PIPE_DATA_W-1:0] data;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid flag plus payload. Clear drops only the valid flag; payload keeps its
// last value so outputs show stale data rather than toggling on a kill.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_o <= 1'b0;
            q_o <= '0;
        end else if (clear_i) begin
            v_o <= 1'b0;
        end else if (load_i) begin
            v_o <= 1'b1;
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer (main + hidden skid),
// valid/ready flow control, flush, and global start/stall gating.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int NUM_DATA = PIPE_NUM_DATA,
    parameter int CTRL_W   = PIPE_CTRL_W,
    parameter int ADDR_W   = PIPE_ADDR_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    input  logic [NUM_DATA*DATA_W-1:0] data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [ADDR_W-1:0]          rd_addr_o,
    output logic [NUM_DATA*DATA_W-1:0] data_o
);

    typedef struct packed {
        logic [CTRL_W-1:0]          ctrl;
        logic [ADDR_W-1:0]          rd_addr;
        logic [NUM_DATA*DATA_W-1:0] data;
    } entry_t;

    localparam int ENT_W = $bits(entry_t);

    entry_t in_ent;
    entry_t m_ent;
    entry_t s_ent;
    entry_t m_d;
    logic   m_v;
    logic   s_v;
    logic   en;
    logic   acc_in;
    logic   acc_out;
    logic   m_load;
    logic   m_clr;
    logic   s_load;
    logic   s_clr;

    assign in_ent = '{ctrl: ctrl_i, rd_addr: rd_addr_i, data: data_i};

    assign en         = start_i & ~stall_i;
    assign in_ready_o = en & ~s_v;
    assign acc_in     = in_valid_i & in_ready_o;
    assign acc_out    = m_v & out_ready_i & en;

    // Main refills from skid first so nothing overtakes the older skid entry.
    // acc_in/acc_out already imply en, so en=0 naturally holds both entries.
    assign m_d    = s_v ? s_ent : in_ent;
    assign m_load = ~flush_i & ((~m_v & acc_in) | (acc_out & (s_v | acc_in)));
    assign m_clr  = flush_i | (acc_out & ~s_v & ~acc_in);
    assign s_load = ~flush_i & m_v & ~acc_out & acc_in;
    assign s_clr  = flush_i | (s_v & acc_out);

    pipe_entry_reg #(.W(ENT_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (m_load),
        .clear_i (m_clr),
        .d_i     (m_d),
        .v_o     (m_v),
        .q_o     (m_ent)
    );

    pipe_entry_reg #(.W(ENT_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (s_load),
        .clear_i (s_clr),
        .d_i     (in_ent),
        .v_o     (s_v),
        .q_o     (s_ent)
    );

    // Control is masked on bubbles so RegWrite can never fire on a stale entry.
    assign out_valid_o = m_v;
    assign ctrl_o      = m_ent.ctrl & {CTRL_W{m_v}};
    assign rd_addr_o   = m_ent.rd_addr;
    assign data_o      = m_ent.data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed phases then random traffic, scored against a
// two-deep FIFO reference model of the stage contents.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ctrl_in = '0;
    logic [4:0]  addr_in = '0;
    logic [63:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  ctrl_out;
    logic [4:0]  addr_out;
    logic [63:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    pipe_entry_t mdl[$];

    pipe_stage_skid dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stall_i     (stall),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ctrl_i      (ctrl_in),
        .rd_addr_i   (addr_in),
        .data_i      (data_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .ctrl_o      (ctrl_out),
        .rd_addr_o   (addr_out),
        .data_o      (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the stage holds at most two entries in arrival order; it accepts
    // while it holds fewer than two, and the oldest leaves on a downstream accept.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl.delete();
        end else if (flush) begin
            mdl.delete();
        end else if (start && !stall) begin
            automatic bit can_take = (mdl.size() < 2);
            if (mdl.size() > 0 && out_ready) void'(mdl.pop_front());
            if (in_valid && can_take) mdl.push_back('{ctrl: ctrl_in, rd_addr: addr_in, data: data_in});
        end
    end

    // Monitor: mid-cycle, compare what the DUT presents with the model's head entry.
    always @(negedge clk) begin
        if (!rst) begin
            automatic bit exp_v = (mdl.size() > 0);
            chk("in_ready", 128'(in_ready), 128'(start && !stall && mdl.size() < 2));
            chk("out_valid", 128'(out_valid), 128'(exp_v));
            if (exp_v) begin
                chk("ctrl_o", 128'(ctrl_out), 128'(mdl[0].ctrl));
                chk("rd_addr_o", 128'(addr_out), 128'(mdl[0].rd_addr));
                chk("data_o", 128'(data_out), 128'(mdl[0].data));
            end else begin
                chk("ctrl_o_bubble", 128'(ctrl_out), 128'(0));
            end
        end
    end

    task automatic drv(input logic v, input logic [1:0] c, input logic [4:0] a, input logic [63:0] d);
        in_valid = v;
        ctrl_in  = c;
        addr_in  = a;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_ctrl"}, 128'(ctrl_out), 128'(0));
        chk({tag, "_rd_addr"}, 128'(addr_out), 128'(0));
        chk({tag, "_data"}, 128'(data_out), 128'(0));
    endtask

    initial begin
        // Reset with no clock edge yet seen.
        #1;
        chk_zero_outputs("rst_init");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;

        // Streaming: rd_addr 1..8, one per cycle.
        out_ready = 1'b1;
        for (int n = 1; n <= 8; n++)
            drv(1'b1, 2'(n), 5'(n), {$urandom(), 32'h100 + 32'(n)});
        drv(1'b0, 2'b00, 5'd0, 64'd0);

        // Backpressure for three cycles mid-stream.
        for (int n = 9; n <= 16; n++) begin
            out_ready = !(n >= 11 && n <= 13);
            drv(1'b1, 2'(n), 5'(n), {$urandom(), 32'h100 + 32'(n)});
        end
        out_ready = 1'b1;
        repeat (3) drv(1'b0, 2'b00, 5'd0, 64'd0);

        // Stall for four cycles while traffic is offered.
        drv(1'b1, 2'b11, 5'd20, {32'hA, 32'h120});
        stall = 1'b1;
        repeat (4) drv(1'b1, 2'b10, 5'd21, {32'hB, 32'h121});
        stall = 1'b0;
        repeat (3) drv(1'b0, 2'b00, 5'd0, 64'd0);

        // Fill main and skid, then flush while an input is offered.
        out_ready = 1'b0;
        drv(1'b1, 2'b01, 5'd22, 64'h122);
        drv(1'b1, 2'b11, 5'd23, 64'h123);
        flush = 1'b1;
        drv(1'b1, 2'b11, 5'd24, 64'h124);
        flush = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl", 128'(ctrl_out), 128'(0));
        out_ready = 1'b1;
        drv(1'b0, 2'b00, 5'd0, 64'd0);

        // start_i low blocks capture; first entry appears the cycle after start rises.
        start = 1'b0;
        repeat (2) drv(1'b1, 2'(1 << CTRL_RW_BIT), 5'd7, 64'h777);
        start = 1'b1;
        drv(1'b1, 2'(1 << CTRL_RW_BIT), 5'd7, 64'h777);
        chk("start_out_valid", 128'(out_valid), 128'(1));
        chk("start_ctrl", 128'(ctrl_out), 128'(2'b01));
        chk("start_rd_addr", 128'(addr_out), 128'(5'd7));
        drv(1'b0, 2'b00, 5'd0, 64'd0);

        // Random traffic with occasional mid-stream asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 15) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (i % 150 == 75) begin
                rst = 1'b1;
                #1;
                chk_zero_outputs("rst_mid");
                #1;
                rst = 1'b0;
            end
            drv(1'($urandom_range(0, 1)), 2'($urandom()), 5'($urandom()), {$urandom(), $urandom()});
        end

        // Drain.
        start = 1'b1; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) drv(1'b0, 2'b00, 5'd0, 64'd0);
        chk("drained", 128'(out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
